// File: rtl/stack_sequencer.sv
// -----------------------------------------------------------------------------
// stack_sequencer
//
// Sequences single-word instructions onto an external stack and ALU.
//   PUSH  : one push strobe carrying the 16-bit immediate.
//   POP   : one pop strobe.
//   binary: pop B (top), pop A (next), run A op B through the ALU and push
//           the result back, so occupancy drops by one overall.
// The sequencer keeps its own copy of the stack occupancy (depth) and uses it
// to drop underflowing / overflowing / illegal instructions without touching
// the stack.
//
// Build option:
//   STACK_SEQ_FAULT_EN  defined   -> offending instructions raise a sticky
//                                    fault (fault/fault_code) that blocks
//                                    instr_ready until fault_clr.
//                       undefined -> offending instructions are dropped
//                                    silently; fault outputs are tied low.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   instr_valid/instr/      instruction handshake; opcode instr[31:26],
//   instr_ready             immediate instr[15:0]
//   stk_push/stk_pop/       one-cycle stack strobes and push data
//   stk_wdata
//   stk_rdata               combinational top-of-stack from the stack
//   alu_op/alu_a/alu_b      ALU select and operands
//   alu_result              combinational ALU result
//   busy                    sequencer is not idle
//   depth                   current stack occupancy
//   fault/fault_code        sticky error flag and cause (01 underflow,
//                           10 overflow, 11 illegal opcode)
//   fault_clr               clears the fault
// -----------------------------------------------------------------------------
module stack_sequencer #(
  parameter int DEPTH = 16,
  parameter int DW    = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   instr_valid,
  input  logic [31:0]            instr,
  output logic                   instr_ready,
  output logic                   stk_push,
  output logic                   stk_pop,
  output logic [DW-1:0]          stk_wdata,
  input  logic [DW-1:0]          stk_rdata,
  output logic [3:0]             alu_op,
  output logic [DW-1:0]          alu_a,
  output logic [DW-1:0]          alu_b,
  input  logic [DW-1:0]          alu_result,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   fault,
  output logic [1:0]             fault_code,
  input  logic                   fault_clr
);

  localparam int                 DEPTH_W    = $clog2(DEPTH) + 1;
  localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(DEPTH);

  localparam logic [5:0] OPC_PUSH = 6'h01;
  localparam logic [5:0] OPC_POP  = 6'h02;
  localparam logic [5:0] OPC_ADD  = 6'h03;
  localparam logic [5:0] OPC_OR   = 6'h04;
  localparam logic [5:0] OPC_SUB  = 6'h05;
  localparam logic [5:0] OPC_SLT  = 6'h06;
  localparam logic [5:0] OPC_NOR  = 6'h07;

  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_UNDERFLOW = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_POP,
    S_POP_A,
    S_POP_B,
    S_EXEC,
    S_PUSH_R
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [DW-1:0]      imm_q;
  logic [DW-1:0]      a_q;
  logic [DW-1:0]      b_q;
  logic [DW-1:0]      r_q;
  logic [3:0]         op_q;
  logic [DEPTH_W-1:0] depth_q;

  logic               is_push;
  logic               is_pop;
  logic               is_bin;
  logic [3:0]         bin_op;
  logic [1:0]         err_code;
  logic               accept;
  logic               go;

  // Only the opcode and immediate fields carry meaning.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[25:16];

  // ---------------------------------------------------------------------------
  // Instruction decode and admission check against the current occupancy.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    is_push = 1'b0;
    is_pop  = 1'b0;
    is_bin  = 1'b0;
    bin_op  = ALU_NONE;
    case (instr[31:26])
      OPC_PUSH: is_push = 1'b1;
      OPC_POP:  is_pop  = 1'b1;
      OPC_ADD:  begin is_bin = 1'b1; bin_op = ALU_ADD; end
      OPC_OR:   begin is_bin = 1'b1; bin_op = ALU_OR;  end
      OPC_SUB:  begin is_bin = 1'b1; bin_op = ALU_SUB; end
      OPC_SLT:  begin is_bin = 1'b1; bin_op = ALU_SLT; end
      OPC_NOR:  begin is_bin = 1'b1; bin_op = ALU_NOR; end
      default:  ;
    endcase
  end

  always_comb begin
    err_code = ERR_NONE;
    if (!(is_push || is_pop || is_bin))       err_code = ERR_ILLEGAL;
    else if (is_push && depth_q == DEPTH_FULL) err_code = ERR_OVERFLOW;
    else if (is_pop && depth_q == '0)          err_code = ERR_UNDERFLOW;
    else if (is_bin && depth_q < DEPTH_W'(2))  err_code = ERR_UNDERFLOW;
  end

  // An accepted instruction with an error is consumed but starts nothing.
  assign accept = instr_valid && instr_ready;
  assign go     = accept && (err_code == ERR_NONE);

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (go) begin
          if (is_push)     state_next = S_PUSH;
          else if (is_pop) state_next = S_POP;
          else             state_next = S_POP_A;
        end
      end
      S_PUSH, S_POP, S_PUSH_R: state_next = S_IDLE;
      S_POP_A:                 state_next = S_POP_B;
      S_POP_B:                 state_next = S_EXEC;
      S_EXEC:                  state_next = S_PUSH_R;
      default:                 state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from the state; the data paths come from registers so
  // all of them fall to zero the moment reset is applied.
  // ---------------------------------------------------------------------------
  assign busy      = (state != S_IDLE);
  assign stk_push  = (state == S_PUSH) || (state == S_PUSH_R);
  assign stk_pop   = (state == S_POP) || (state == S_POP_A) || (state == S_POP_B);
  assign stk_wdata = (state == S_PUSH)   ? imm_q :
                     (state == S_PUSH_R) ? r_q   : '0;
  assign alu_op    = (state == S_EXEC || state == S_PUSH_R) ? op_q : ALU_NONE;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign depth     = depth_q;

  // ---------------------------------------------------------------------------
  // State, operand and occupancy registers.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the operand/result registers are reset too, because alu_a,
      // alu_b and stk_wdata must read zero during reset.
      state   <= S_IDLE;
      imm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      op_q    <= ALU_NONE;
      depth_q <= '0;
    end else begin
      state <= state_next;
      if (go) begin
        imm_q <= DW'(instr[15:0]);
        op_q  <= bin_op;
      end
      // Top of stack is read before the pop strobe takes effect: the first
      // pop yields the right operand, the second the left.
      if (state == S_POP_A) b_q <= stk_rdata;
      if (state == S_POP_B) a_q <= stk_rdata;
      if (state == S_EXEC)  r_q <= alu_result;
      if (stk_push)         depth_q <= depth_q + DEPTH_W'(1);
      else if (stk_pop)     depth_q <= depth_q - DEPTH_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Fault reporting.
  // ---------------------------------------------------------------------------
`ifdef STACK_SEQ_FAULT_EN
  logic       fault_q;
  logic [1:0] fault_code_q;

  // fault_clr wins over a coinciding instruction by holding ready low.
  assign instr_ready = (state == S_IDLE) && !fault_q && !fault_clr;
  assign fault       = fault_q;
  assign fault_code  = fault_code_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fault_q      <= 1'b0;
      fault_code_q <= ERR_NONE;
    end else if (fault_clr) begin
      fault_q      <= 1'b0;
      fault_code_q <= ERR_NONE;
    end else if (accept && err_code != ERR_NONE) begin
      fault_q      <= 1'b1;
      fault_code_q <= err_code;
    end
  end
`else
  logic unused_fault_clr;
  assign unused_fault_clr = fault_clr;

  assign instr_ready = (state == S_IDLE);
  assign fault       = 1'b0;
  assign fault_code  = ERR_NONE;
`endif

endmodule

// File: tb/tb_stack_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stack_sequencer
//
// Drives directed and random instruction streams into stack_sequencer, with a
// behavioural stack and ALU attached. A reference model (a queue holding the
// expected stack contents) predicts, per accepted instruction, the ordered
// list of stack/ALU events; a negedge monitor pops that list as the DUT
// strobes and compares. Occupancy, fault state and latency are compared when
// each instruction completes. Works with and without STACK_SEQ_FAULT_EN.
// -----------------------------------------------------------------------------
module tb_stack_sequencer;

  localparam int DEPTH   = 16;
  localparam int DW      = 16;
  localparam int DEPTH_W = $clog2(DEPTH) + 1;

  localparam int EV_PUSH = 0;
  localparam int EV_POP  = 1;
  localparam int EV_EXEC = 2;

  logic                clock = 1'b0;
  logic                reset;
  logic                instr_valid;
  logic [31:0]         instr;
  logic                instr_ready;
  logic                stk_push;
  logic                stk_pop;
  logic [DW-1:0]       stk_wdata;
  logic [DW-1:0]       stk_rdata;
  logic [3:0]          alu_op;
  logic [DW-1:0]       alu_a;
  logic [DW-1:0]       alu_b;
  logic [DW-1:0]       alu_result;
  logic                busy;
  logic [DEPTH_W-1:0]  depth;
  logic                fault;
  logic [1:0]          fault_code;
  logic                fault_clr;

  int n_checks = 0;
  int n_errors = 0;
  int push_seen = 0;

  always #5 clock = ~clock;

  stack_sequencer #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clock       (clock),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .stk_push    (stk_push),
    .stk_pop     (stk_pop),
    .stk_wdata   (stk_wdata),
    .stk_rdata   (stk_rdata),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .busy        (busy),
    .depth       (depth),
    .fault       (fault),
    .fault_code  (fault_code),
    .fault_clr   (fault_clr)
  );

  // ---------------- attached stack (environment) ----------------
  logic [DW-1:0] stk_mem [0:DEPTH];
  int            stk_sp;

  assign stk_rdata = (stk_sp > 0) ? stk_mem[stk_sp-1] : '0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      stk_sp <= 0;
    end else if (stk_push) begin
      if (stk_sp <= DEPTH) stk_mem[stk_sp] <= stk_wdata;
      stk_sp <= stk_sp + 1;
    end else if (stk_pop) begin
      if (stk_sp > 0) stk_sp <= stk_sp - 1;
    end
  end

  // ---------------- attached ALU (environment) ----------------
  always_comb begin
    case (alu_op)
      4'b0010: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? DW'(1) : DW'(0);
      4'b1100: alu_result = ~(alu_a | alu_b);
      default: alu_result = '0;
    endcase
  end

  // ---------------- reference model ----------------
  typedef struct {
    int            kind;
    logic [DW-1:0] data;
    bit            chk_op;
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } ev_t;

  ev_t           exp_q[$];
  logic [DW-1:0] ref_stk[$];
  logic          ref_fault = 1'b0;
  logic [1:0]    ref_code  = 2'b00;

  function automatic ev_t mk_ev(input int kind, input logic [DW-1:0] data,
                                input bit chk_op, input logic [3:0] op,
                                input logic [DW-1:0] a, input logic [DW-1:0] b);
    ev_t e;
    e.kind = kind; e.data = data; e.chk_op = chk_op; e.op = op; e.a = a; e.b = b;
    return e;
  endfunction

  function automatic logic [3:0] exp_alu_op(input logic [5:0] opc);
    case (opc)
      6'h03:   return 4'b0010;
      6'h04:   return 4'b0001;
      6'h05:   return 4'b0110;
      6'h06:   return 4'b0111;
      default: return 4'b1100;
    endcase
  endfunction

  function automatic logic [DW-1:0] ref_alu(input logic [5:0] opc,
                                            input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (opc)
      6'h03:   return a + b;
      6'h04:   return a | b;
      6'h05:   return a - b;
      6'h06:   return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
      default: return ~(a | b);
    endcase
  endfunction

  // Applies an accepted instruction to the model; returns expected cycles
  // from acceptance until the sequencer is idle again.
  task automatic model_accept(input logic [31:0] ins, output int exp_lat);
    logic [5:0]    opc;
    logic [DW-1:0] a, b, r, imm;
    logic [1:0]    err;
    opc = ins[31:26];
    imm = ins[15:0];
    err = 2'b00;
    if (opc < 6'h01 || opc > 6'h07)                    err = 2'b11;
    else if (opc == 6'h01 && ref_stk.size() == DEPTH)  err = 2'b10;
    else if (opc == 6'h02 && ref_stk.size() == 0)      err = 2'b01;
    else if (opc >= 6'h03 && ref_stk.size() < 2)       err = 2'b01;
    if (err != 2'b00) begin
`ifdef STACK_SEQ_FAULT_EN
      ref_fault = 1'b1;
      ref_code  = err;
`endif
      exp_lat = 1;
    end else if (opc == 6'h01) begin
      ref_stk.push_back(imm);
      exp_q.push_back(mk_ev(EV_PUSH, imm, 1'b1, 4'b0000, '0, '0));
      exp_lat = 2;
    end else if (opc == 6'h02) begin
      void'(ref_stk.pop_back());
      exp_q.push_back(mk_ev(EV_POP, '0, 1'b1, 4'b0000, '0, '0));
      exp_lat = 2;
    end else begin
      b = ref_stk.pop_back();
      a = ref_stk.pop_back();
      r = ref_alu(opc, a, b);
      ref_stk.push_back(r);
      exp_q.push_back(mk_ev(EV_POP, '0, 1'b1, 4'b0000, '0, '0));
      exp_q.push_back(mk_ev(EV_POP, '0, 1'b1, 4'b0000, '0, '0));
      exp_q.push_back(mk_ev(EV_EXEC, '0, 1'b1, exp_alu_op(opc), a, b));
      exp_q.push_back(mk_ev(EV_PUSH, r, 1'b0, 4'b0000, '0, '0));
      exp_lat = 5;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  ev_t mon_ev;
  int  mon_kind;

  always @(negedge clock) begin
    if (!reset) begin
      check("strobe_exclusive", {31'b0, stk_push & stk_pop}, 32'd0);
      if (stk_push) push_seen++;
      if (stk_push || stk_pop || busy) begin
        mon_kind = stk_push ? EV_PUSH : (stk_pop ? EV_POP : EV_EXEC);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_activity: kind %0d seen, no event expected (t=%0t)",
                   mon_kind, $time);
        end else begin
          mon_ev = exp_q.pop_front();
          check("event_kind", mon_kind, mon_ev.kind);
          if (mon_ev.kind == EV_PUSH) check("push_data", stk_wdata, mon_ev.data);
          if (mon_ev.chk_op)          check("alu_op", alu_op, mon_ev.op);
          if (mon_ev.kind == EV_EXEC) begin
            check("alu_a", alu_a, mon_ev.a);
            check("alu_b", alu_b, mon_ev.b);
          end
        end
      end else begin
        check("idle_alu_op", alu_op, 4'b0000);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] mk_instr(input logic [5:0] opc, input logic [15:0] imm);
    return {opc, 10'($urandom), imm};
  endfunction

  task automatic issue(input logic [31:0] ins);
    int n, lat, exp_lat;
    @(negedge clock);
    instr       = ins;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!instr_ready) begin
      check("ready_timeout", {31'b0, instr_ready}, 32'd1);
      instr_valid = 1'b0;
      return;
    end
    model_accept(ins, exp_lat);
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    instr       = $urandom;
    lat = 1;
    while (busy && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    check("depth", depth, ref_stk.size());
    check("fault", {31'b0, fault}, {31'b0, ref_fault});
    check("fault_code", fault_code, ref_code);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset       = 1'b1;
    instr_valid = 1'b0;
    fault_clr   = 1'b0;
    exp_q.delete();
    ref_stk.delete();
    ref_fault = 1'b0;
    ref_code  = 2'b00;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

`ifdef STACK_SEQ_FAULT_EN
  // Pulses fault_clr together with a valid PUSH that must not be taken.
  task automatic clear_fault();
    @(negedge clock);
    check("ready_while_fault", {31'b0, instr_ready}, 32'd0);
    instr       = mk_instr(6'h01, 16'h1234);
    instr_valid = 1'b1;
    fault_clr   = 1'b1;
    #1;
    check("ready_during_clr", {31'b0, instr_ready}, 32'd0);
    @(posedge clock);
    #1;
    fault_clr   = 1'b0;
    instr_valid = 1'b0;
    check("fault_cleared", {31'b0, fault}, 32'd0);
    check("code_cleared", fault_code, 2'b00);
    check("no_accept_on_clr", {31'b0, busy}, 32'd0);
    ref_fault = 1'b0;
    ref_code  = 2'b00;
  endtask
`endif

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int saved_push, r;
    logic [5:0] opc;

    reset       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    fault_clr   = 1'b0;
    #1 reset = 1'b1;
    @(negedge clock);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_depth", depth, 0);
    check("rst_fault", {31'b0, fault}, 32'd0);
    check("rst_fault_code", fault_code, 2'b00);
    check("rst_push", {31'b0, stk_push}, 32'd0);
    check("rst_pop", {31'b0, stk_pop}, 32'd0);
    check("rst_wdata", stk_wdata, 0);
    check("rst_alu_op", alu_op, 4'b0000);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_ready", {31'b0, instr_ready}, 32'd1);
    @(negedge clock);
    reset = 1'b0;

    // PUSH 5, PUSH 3, SUB -> 2
    issue(mk_instr(6'h01, 16'd5));
    issue(mk_instr(6'h01, 16'd3));
    issue(mk_instr(6'h05, 16'($urandom)));
    check("sub_top", stk_rdata, 16'h0002);
    check("sub_depth", depth, 1);

    // PUSH 2, PUSH 7, SLT -> 1
    do_reset();
    issue(mk_instr(6'h01, 16'd2));
    issue(mk_instr(6'h01, 16'd7));
    issue(mk_instr(6'h06, 16'd0));
    check("slt_top", stk_rdata, 16'h0001);

    // ADD with a single entry -> underflow
    do_reset();
    issue(mk_instr(6'h01, 16'hBEEF));
    issue(mk_instr(6'h03, 16'd0));
    check("underflow_depth", depth, 1);
`ifdef STACK_SEQ_FAULT_EN
    check("underflow_code", fault_code, 2'b01);
    repeat (3) begin
      @(negedge clock);
      check("underflow_ready_low", {31'b0, instr_ready}, 32'd0);
    end
    clear_fault();
`else
    @(negedge clock);
    check("underflow_ready_not_gated", {31'b0, instr_ready}, 32'd1);
`endif

    // Fill to capacity, then overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) issue(mk_instr(6'h01, 16'(i * 257)));
    issue(mk_instr(6'h01, 16'hFFFF));
    check("overflow_depth", depth, DEPTH);
`ifdef STACK_SEQ_FAULT_EN
    check("overflow_code", fault_code, 2'b10);
    clear_fault();
`endif
    issue(mk_instr(6'h02, 16'd0));
    check("pop_after_full_depth", depth, DEPTH - 1);

    // Illegal opcode 0x3F
    issue(mk_instr(6'h3F, 16'd0));
`ifdef STACK_SEQ_FAULT_EN
    check("illegal_code", fault_code, 2'b11);
    clear_fault();
`endif
    issue(mk_instr(6'h01, 16'h00AA));

    // Random stream
    do_reset();
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 11);
      if (r < 5)       opc = 6'h01;
      else if (r == 5) opc = 6'h02;
      else if (r < 11) opc = 6'(r - 3);
      else             opc = ($urandom_range(0, 1) == 0) ? 6'h00 : 6'($urandom_range(8, 63));
      issue(mk_instr(opc, 16'($urandom)));
`ifdef STACK_SEQ_FAULT_EN
      if (ref_fault) clear_fault();
`endif
    end
    check("random_env_depth", stk_sp, ref_stk.size());
    if (ref_stk.size() > 0) check("random_top", stk_rdata, ref_stk[ref_stk.size()-1]);

    // Reset during EXEC
    do_reset();
    issue(mk_instr(6'h01, 16'd10));
    issue(mk_instr(6'h01, 16'd20));
    @(negedge clock);
    instr       = mk_instr(6'h03, 16'd0);
    instr_valid = 1'b1;
    begin
      int dummy_lat;
      model_accept(instr, dummy_lat);
    end
    @(posedge clock); #1;
    instr_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("exec_reached_busy", {31'b0, busy}, 32'd1);
    check("exec_reached_op", alu_op, 4'b0010);
    saved_push = push_seen;
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_push", {31'b0, stk_push}, 32'd0);
    check("midrst_pop", {31'b0, stk_pop}, 32'd0);
    check("midrst_wdata", stk_wdata, 0);
    check("midrst_alu_op", alu_op, 4'b0000);
    check("midrst_alu_a", alu_a, 0);
    check("midrst_alu_b", alu_b, 0);
    check("midrst_depth", depth, 0);
    check("midrst_fault", {29'b0, fault, fault_code}, 32'd0);
    exp_q.delete();
    ref_stk.delete();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    check("midrst_no_push_after", push_seen, saved_push);
    issue(mk_instr(6'h01, 16'h5A5A));

    check("events_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
